// File: rtl/bram_stream_reader_if.sv
// Output stream bundle of the BRAM stream reader.
// Valid/ready handshake with a per-beat last marker.
interface bram_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic                  m_last_o;

    modport master (
        output m_data_o,
        output m_valid_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_data_o,
        input  m_valid_o,
        input  m_last_o,
        output m_ready_i
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Walks a contiguous BRAM address range and streams the words out.
// A 2-entry buffer absorbs the 1-cycle read latency under backpressure.
module bram_stream_reader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int LENGTH_WIDTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic [ADDRESS_WIDTH-1:0] base_address_i,
    input  logic [LENGTH_WIDTH-1:0]  length_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ADDRESS_WIDTH-1:0] rd_address_o,
    output logic                     rd_enable_o,
    input  logic [DATA_WIDTH-1:0]    rd_data_i,
    input  logic                     rd_valid_i,
    bram_stream_reader_if.master     m
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_e;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LENGTH_WIDTH-1:0]  LEN_ONE  = 1;

    state_e                    state_q;
    logic [ADDRESS_WIDTH-1:0]  addr_q;
    logic [LENGTH_WIDTH-1:0]   issue_q;
    logic                      inflight_q;
    logic                      inflight_last_q;
    logic                      done_q;

    logic [1:0]                count_q, count_d;
    logic [DATA_WIDTH-1:0]     data0_q, data0_d;
    logic [DATA_WIDTH-1:0]     data1_q, data1_d;
    logic                      last0_q, last0_d;
    logic                      last1_q, last1_d;

    logic                      push;
    logic                      pop;
    logic [2:0]                occ_next;

    assign push = rd_valid_i;
    assign pop  = m.m_valid_o & m.m_ready_i;

    // Occupancy once this cycle's returning word and handshake settle;
    // a new read is only issued if its word is guaranteed a slot.
    assign occ_next = {1'b0, count_q} + {2'b00, inflight_q}
                    - {2'b00, pop};

    assign rd_enable_o = (state_q == READ) && (issue_q != '0)
                      && (occ_next < 3'd2);

    assign rd_address_o = addr_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;

    assign m.m_data_o  = data0_q;
    assign m.m_valid_o = (count_q != 2'd0);
    assign m.m_last_o  = last0_q & (count_q != 2'd0);

    // Burst sequencer: command capture, read issue and completion.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            issue_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= rd_enable_o;
            inflight_last_q <= rd_enable_o && (issue_q == LEN_ONE);
            if (rd_enable_o) begin
                addr_q  <= addr_q + ADDR_ONE;
                issue_q <= issue_q - LEN_ONE;
            end
            unique case (state_q)
                IDLE: begin
                    if (start_i && (length_i != '0)) begin
                        addr_q  <= base_address_i;
                        issue_q <= length_i;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (rd_enable_o && (issue_q == LEN_ONE)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && m.m_last_o) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-entry shift buffer; entry 0 is always the stream head.
    always_comb begin
        count_d = count_q;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    data0_d = rd_data_i;
                    last0_d = inflight_last_q;
                    count_d = 2'd1;
                end else begin
                    data1_d = rd_data_i;
                    last1_d = inflight_last_q;
                    count_d = 2'd2;
                end
            end
            2'b01: begin
                data0_d = data1_q;
                last0_d = last1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    data0_d = rd_data_i;
                    last0_d = inflight_last_q;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = rd_data_i;
                    last1_d = inflight_last_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Buffer storage registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            count_q <= count_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
        end
    end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side sequencer placed directly downstream of the simple dual-port BRAM.
- On a start command it walks a contiguous address range through the BRAM read port (1-cycle registered read latency, rd_valid qualified).
- It returns the words as a valid/ready stream with a last marker.
- A 2-entry output buffer absorbs the read latency, so backpressure never loses data and a held-high m_ready_i gives one beat per cycle.

Parameters:
- DATA_WIDTH, 8, stream and BRAM data width in bits.
- ADDRESS_WIDTH, 8, BRAM address width; addresses wrap modulo 2^ADDRESS_WIDTH.
- LENGTH_WIDTH, 16, width of the burst-length field.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle command strobe; accepted only in IDLE.
- base_address_i  input  ADDRESS_WIDTH  first read address, sampled with start_i.
- length_i  input  LENGTH_WIDTH  number of words to read, sampled with start_i; 0 is illegal.
- busy_o  output  1  high from the accepted start until the last beat's handshake.
- done_o  output  1  one-cycle pulse on the cycle after the last beat's handshake.
- rd_address_o  output  ADDRESS_WIDTH  to BRAM rd_address_i.
- rd_enable_o  output  1  to BRAM rd_enable_i; one read per cycle it is high.
- rd_data_i  input  DATA_WIDTH  from BRAM rd_data_o.
- rd_valid_i  input  1  from BRAM rd_valid_o; marks rd_data_i valid this cycle.
- m_data_o  output  DATA_WIDTH  stream data.
- m_valid_o  output  1  stream valid.
- m_ready_i  input  1  stream ready.
- m_last_o  output  1  high with the final beat of the burst.

Behaviour:
- Reset (async assert, sync release) clears state to IDLE, buffer empty, counters 0.
- Reset values: busy_o=0, done_o=0, rd_enable_o=0, rd_address_o=0, m_valid_o=0, m_last_o=0, m_data_o=0.
- Reset mid-burst aborts the burst: no done_o pulse, and in-flight data is discarded.
- States:
  - IDLE: start_i=1 and length_i!=0 -> latch address and remaining issue count, then go to READ. start_i with length_i=0 is ignored (stay IDLE, no done_o).
  - READ: issues reads. When the issue count reaches 0 -> DRAIN.
  - DRAIN: waits until all beats are handshaken -> IDLE, with done_o pulsing on the cycle after the last handshake.
- start_i outside IDLE is ignored.
- rd_enable_o is combinational: high in READ when issue count > 0 and (occupancy + inflight - pop) < 2.
  - pop = m_valid_o & m_ready_i.
  - inflight = 1 if a read was issued on the previous cycle.
  - This guarantees every returning word has a buffer slot.
- rd_address_o is a register. It holds base_address_i after start and increments by 1 per issued read, wrapping from 2^ADDRESS_WIDTH-1 to 0.
- Buffer write occurs when rd_valid_i=1. It is a 2-entry FIFO; m_data_o/m_valid_o come from the head entry, which is registered.
- Simultaneous push and pop is allowed, and occupancy is unchanged.
- rd_valid_i while the buffer is full is impossible by construction. Verification asserts it never happens.
- m_data_o and m_last_o hold stable while m_valid_o=1 and m_ready_i=0.
- m_last_o is stored per entry: set on the word that corresponds to the final issued read.
- Latency: start sampled at edge E0 -> rd_enable_o=1, rd_address_o=base after E0 -> BRAM data after E1 -> m_valid_o=1 after E2.
- Throughput: 1 beat/cycle with m_ready_i held high.
- busy_o is high from E0 through the last handshake edge. done_o is high for exactly the one cycle that follows.

Test Plan:
- Basic burst: base=0x10, length=4, BRAM[0x10..0x13]=A0..A3, m_ready_i=1 -> m_valid_o first high 2 cycles after start; beats A0,A1,A2,A3 on consecutive cycles; m_last_o only on A3; done_o pulses once; busy_o low afterwards.
- Backpressure: length=6, m_ready_i toggled 1,0,0,1,0,1... -> data order unchanged; m_data_o stable while stalled; rd_enable_o never high when occupancy+inflight would exceed 2; no rd_valid_i while the buffer is full.
- Address wrap: ADDRESS_WIDTH=8, base=0xFE, length=4 -> rd_address_o sequence 0xFE,0xFF,0x00,0x01; data matches those locations.
- Single word and zero length: length=1 -> one beat with m_last_o=1 and a done_o pulse. length=0 -> busy_o stays 0, no reads, no done_o.
- Start while busy: a second start_i pulse during a burst of 8 -> ignored; exactly 8 beats; rd_address_o never reloads.
- Reset mid-burst: assert rst_n_i=0 after 3 of 8 beats -> all outputs 0 immediately; after release, a new burst base=0x40, length=2 runs cleanly with no stale data.
